// File: rtl/rf_pkg.sv
// Shared definitions for the register-file access arbiter: RF address window,
// controller state encoding and the RF address decode used by the optional
// address check (RF_ADDR_CHECK_EN).
package rf_pkg;

    localparam logic [15:0] RF_BASE = 16'h0100;
    localparam logic [15:0] RF_LAST = 16'h0122;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_RD      = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_ACK     = 3'd4,
        ST_ERR     = 3'd5
    } rf_arb_state_t;

    // The 23 registers sit at decimal-looking offsets: 0x00-0x09, 0x10-0x19, 0x20-0x22.
    function automatic logic rf_addr_valid(input logic [15:0] addr);
        return (addr[15:8] == RF_BASE[15:8]) &&
               (addr[7:4] <= 4'd2) &&
               (addr[3:0] <= 4'd9) &&
               (addr <= RF_LAST);
    endfunction

endpackage

// File: rtl/rf_rr_pick.sv
// Combinational round-robin picker: searches the request vector starting at
// the priority pointer and wrapping modulo NUM_REQ; returns a one-hot grant
// plus the binary index of the winner.
module rf_rr_pick
    import rf_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);

    logic [IDX_W:0] cand;

    // Scan offsets from farthest to nearest so the requester at the pointer wins last (highest priority).
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr_i} + (IDX_W + 1)'(k);
            if (cand >= (IDX_W + 1)'(NUM_REQ)) begin
                cand = cand - (IDX_W + 1)'(NUM_REQ);
            end
            if (req_i[cand[IDX_W-1:0]]) begin
                grant_o                   = '0;
                grant_o[cand[IDX_W-1:0]]  = 1'b1;
                idx_o                     = cand[IDX_W-1:0];
                valid_o                   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_access_arbiter.sv
// Register-file access arbiter: shares the 23-entry, 64-bit RF between
// NUM_REQ requesters with round-robin priority, one transaction at a time.
// Writes ack two cycles after the request is sampled, reads three (the RF
// read port is registered). Define RF_ADDR_CHECK_EN to reject addresses
// outside the RF map with a one-cycle ack carrying err=1.
module rf_access_arbiter
    import rf_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 64
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          ack,
    output logic                        err,
    output logic [DATA_W-1:0]           rdata,
    output logic                        busy,
    output logic                        rf_we,
    output logic [ADDR_W-1:0]           rf_addr,
    output logic [DATA_W-1:0]           rf_wdata,
    input  logic [DATA_W-1:0]           rf_rdata
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    rf_arb_state_t       state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic [NUM_REQ-1:0]  pick_grant;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_valid;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_we;
    logic                sel_ok;

    function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] i);
        if (i == IDX_W'(NUM_REQ - 1)) begin
            return '0;
        end
        return i + 1'b1;
    endfunction

    rf_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    assign sel_addr  = req_addr[pick_idx*ADDR_W +: ADDR_W];
    assign sel_wdata = req_wdata[pick_idx*DATA_W +: DATA_W];
    assign sel_we    = req_we[pick_idx];

`ifdef RF_ADDR_CHECK_EN
    assign sel_ok = rf_addr_valid(16'(sel_addr));
`else
    assign sel_ok = 1'b1;
`endif

    // Next-state logic: latch the winner in IDLE, walk the access sequence, advance priority on completion.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    idx_d   = pick_idx;
                    grant_d = pick_grant;
                    addr_d  = sel_addr;
                    if (sel_we) begin
                        wdata_d = sel_wdata;
                    end
                    if (!sel_ok) begin
                        state_d = ST_ERR;
                    end else if (sel_we) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_WR:      state_d = ST_ACK;
            ST_RD:      state_d = ST_RD_WAIT;
            ST_RD_WAIT: begin
                rdata_d = rf_rdata;
                state_d = ST_ACK;
            end
            ST_ACK, ST_ERR: begin
                ptr_d   = ptr_after(idx_q);
                state_d = ST_IDLE;
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            grant_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Gating with reset_n keeps an abandoned write from landing on the RF edge that applies reset.
    assign rf_we    = (state_q == ST_WR) && reset_n;
    assign rf_addr  = addr_q;
    assign rf_wdata = wdata_q;
    assign rdata    = rdata_q;
    assign busy     = (state_q != ST_IDLE);
    assign ack      = ((state_q == ST_ACK) || (state_q == ST_ERR)) ? grant_q : '0;

`ifdef RF_ADDR_CHECK_EN
    assign err = (state_q == ST_ERR);
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Directed scoreboard bench for rf_access_arbiter with a behavioural RF model.
// Address-rejection steps run only when RF_ADDR_CHECK_EN is defined.
module tb_rf_access_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 64;

    localparam logic [63:0] D_W1 = 64'hDEAD_BEEF_0000_0001;
    localparam logic [63:0] D_A  = 64'h1111_2222_3333_0100;
    localparam logic [63:0] D_B  = 64'hAAAA_BBBB_CCCC_0122;
    localparam logic [63:0] D_V1 = 64'h0707_0707_0000_0001;
    localparam logic [63:0] D_V2 = 64'h0707_0707_0000_0002;

    logic                      clk;
    logic                      reset_n;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        ack;
    logic                      err;
    logic [DATA_W-1:0]         rdata;
    logic                      busy;
    logic                      rf_we;
    logic [ADDR_W-1:0]         rf_addr;
    logic [DATA_W-1:0]         rf_wdata;
    logic [DATA_W-1:0]         rf_rdata;

    rf_access_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .ack       (ack),
        .err       (err),
        .rdata     (rdata),
        .busy      (busy),
        .rf_we     (rf_we),
        .rf_addr   (rf_addr),
        .rf_wdata  (rf_wdata),
        .rf_rdata  (rf_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model with a one-cycle registered read port.
    logic [63:0] rf_mem [0:255];
    always @(posedge clk) begin
        if (rf_we) rf_mem[rf_addr[7:0]] <= rf_wdata;
        rf_rdata <= rf_mem[rf_addr[7:0]];
    end

    // Count RF write strobes and remember the last written address.
    int          we_cnt = 0;
    logic [15:0] we_addr = '0;
    always @(posedge clk) begin
        if (rf_we) begin
            we_cnt  <= we_cnt + 1;
            we_addr <= rf_addr;
        end
    end

    typedef struct {
        int          idx;
        logic        err;
        logic [63:0] data;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic issue(input int i, input logic we, input logic [15:0] a, input logic [63:0] d);
        req_we[i]               = we;
        req_addr[i*ADDR_W +: ADDR_W]    = a;
        req_wdata[i*DATA_W +: DATA_W]   = d;
        req[i]                  = 1'b1;
    endtask

    task automatic expect_txn(input int i, input logic e, input logic [63:0] d, input int lat);
        exp_t x;
        x.idx = i; x.err = e; x.data = d; x.lat = lat;
        sb.push_back(x);
    endtask

    // Wait (bounded) for the next ack, compare it against the scoreboard head, then confirm it lasted one cycle.
    task automatic wait_ack(input bit drop);
        exp_t        e;
        int          n;
        logic        seen;
        logic [1:0]  oh;
        if (sb.size() == 0) begin
            chk("sb_empty", 64'(sb.size()), 64'd1);
            return;
        end
        e = sb.pop_front();
        n = 0;
        seen = 1'b0;
        while (!seen && n < 30) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (ack != '0) seen = 1'b1;
        end
        chk("ack_seen", 64'(seen), 64'd1);
        if (seen) begin
            oh = 2'b01 << e.idx;
            chk("ack_onehot", 64'(ack), 64'(oh));
            chk("err", 64'(err), 64'(e.err));
            chk("rdata", rdata, e.data);
            chk("latency", 64'(n), 64'(e.lat));
            if (drop) req[e.idx] = 1'b0;
            @(posedge clk);
            @(negedge clk);
            chk("ack_single", 64'(ack), 64'd0);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ack"},      64'(ack),      64'd0);
        chk({tag, "_err"},      64'(err),      64'd0);
        chk({tag, "_rdata"},    rdata,         64'd0);
        chk({tag, "_busy"},     64'(busy),     64'd0);
        chk({tag, "_rf_we"},    64'(rf_we),    64'd0);
        chk({tag, "_rf_addr"},  64'(rf_addr),  64'd0);
        chk({tag, "_rf_wdata"}, rf_wdata,      64'd0);
    endtask

    initial begin
        int we0;
        reset_n   = 1'b0;
        req       = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Write from requester 0, then read it back from requester 1
        we0 = we_cnt;
        issue(0, 1'b1, 16'h0105, D_W1);
        expect_txn(0, 1'b0, 64'd0, 2);
        wait_ack(1'b1);
        chk("wr_strobe_count", 64'(we_cnt - we0), 64'd1);
        chk("wr_strobe_addr",  64'(we_addr), 64'h0105);

        issue(1, 1'b0, 16'h0105, 64'd0);
        expect_txn(1, 1'b0, D_W1, 3);
        wait_ack(1'b1);

        // Load the two arbitration targets
        issue(0, 1'b1, 16'h0122, D_B);
        expect_txn(0, 1'b0, D_W1, 2);
        wait_ack(1'b1);
        issue(1, 1'b1, 16'h0100, D_A);
        expect_txn(1, 1'b0, D_W1, 2);
        wait_ack(1'b1);

        // Both requesters held: grants must alternate 0,1,0,1
        issue(0, 1'b0, 16'h0100, 64'd0);
        issue(1, 1'b0, 16'h0122, 64'd0);
        expect_txn(0, 1'b0, D_A, 3);
        expect_txn(1, 1'b0, D_B, 3);
        expect_txn(0, 1'b0, D_A, 3);
        expect_txn(1, 1'b0, D_B, 3);
        wait_ack(1'b0);
        wait_ack(1'b0);
        wait_ack(1'b1);
        wait_ack(1'b1);

        // Establish a known value at 0x0107, then abandon an overwrite by reset in WR
        issue(0, 1'b1, 16'h0107, D_V1);
        expect_txn(0, 1'b0, D_B, 2);
        wait_ack(1'b1);
        we0 = we_cnt;
        issue(0, 1'b1, 16'h0107, D_V2);
        @(posedge clk);
        @(negedge clk);
        chk("wr_state_busy", 64'(busy), 64'd1);
        reset_n = 1'b0;
        req     = '0;
        #1;
        chk("rst_wr_rf_we", 64'(rf_we), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check_reset_vals("rst_wr");
        chk("rst_wr_no_write", 64'(we_cnt - we0), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Pointer back at 0: requester 0 wins a tie; 0x0107 still holds the old value
        issue(0, 1'b0, 16'h0107, 64'd0);
        issue(1, 1'b0, 16'h0105, 64'd0);
        expect_txn(0, 1'b0, D_V1, 3);
        expect_txn(1, 1'b0, D_W1, 3);
        wait_ack(1'b1);
        wait_ack(1'b1);

        // Reset while the read is in RD_WAIT
        issue(1, 1'b0, 16'h0105, 64'd0);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("rdw_busy", 64'(busy), 64'd1);
        chk("rdw_ack",  64'(ack),  64'd0);
        reset_n = 1'b0;
        req     = '0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_rdw_busy",  64'(busy), 64'd0);
        chk("rst_rdw_ack",   64'(ack),  64'd0);
        chk("rst_rdw_rdata", rdata,     64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        issue(1, 1'b0, 16'h0105, 64'd0);
        expect_txn(1, 1'b0, D_W1, 3);
        wait_ack(1'b1);

`ifdef RF_ADDR_CHECK_EN
        // Rejected addresses: one-cycle err ack, no RF write, rdata untouched
        we0 = we_cnt;
        issue(0, 1'b1, 16'h010A, 64'h1234);
        expect_txn(0, 1'b1, D_W1, 1);
        wait_ack(1'b1);
        issue(1, 1'b1, 16'h0123, 64'h5678);
        expect_txn(1, 1'b1, D_W1, 1);
        wait_ack(1'b1);
        chk("err_no_write", 64'(we_cnt - we0), 64'd0);
        issue(0, 1'b0, 16'h0122, 64'd0);
        expect_txn(0, 1'b0, D_B, 3);
        wait_ack(1'b1);
`endif

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
